afifo_rd_stream: RTL and testbench

- Read-side drain engine for AFIFO. Sits in the read clock domain, pops words through AFIFO's rd_en/rdata/rd_empty port and re-presents them as a valid/ready stream (m_*).
- Absorbs AFIFO's 1-cycle read latency with a small output buffer, so back-to-back transfers run without bubbles.
- Maintains a delivered-word counter and supports a synchronous flush.

---
 rtl/afifo_rd_stream_if.sv | 32 +++
 rtl/afifo_rd_stream.sv | 92 +++++++++
 tb/tb_afifo_rd_stream.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/afifo_rd_stream_if.sv
// Handshake bundle for the AFIFO read drain engine: the AFIFO pop port
// (rd_en/rdata/rd_empty) and the downstream valid/ready stream (m_*).
interface afifo_rd_stream_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  rd_en;
  logic                  rd_empty;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;

  // Drain engine side: pops AFIFO, presents the stream.
  modport master (
    output rd_en,
    input  rd_empty,
    input  rdata,
    output m_valid,
    output m_data,
    input  m_ready
  );

  // AFIFO + downstream consumer side.
  modport slave (
    input  rd_en,
    output rd_empty,
    output rdata,
    input  m_valid,
    input  m_data,
    output m_ready
  );
endinterface

// File: rtl/afifo_rd_stream.sv
// Read-side drain engine: pops AFIFO words, hides the 1-cycle read latency
// behind a small shift-style output buffer and re-presents them as a
// valid/ready stream. Counts delivered words and supports a synchronous flush.
module afifo_rd_stream #(
  parameter  int DATA_WIDTH = 32,
  parameter  int BUF_DEPTH  = 2,
  parameter  int CNT_WIDTH  = 16,
  localparam int LVL_W      = $clog2(BUF_DEPTH + 1),
  localparam int IDX_W      = $clog2(BUF_DEPTH)
) (
  input  logic                  clk_rd,
  input  logic                  rst_rd,
  afifo_rd_stream_if.master     bus,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic [LVL_W-1:0]      buf_level
);

  logic [DATA_WIDTH-1:0] r_buf [BUF_DEPTH];
  logic [LVL_W-1:0]      r_level;
  logic                  r_inflight;
  logic [CNT_WIDTH-1:0]  r_cnt;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_rd_en;
  logic [LVL_W:0]        w_committed;
  logic [LVL_W-1:0]      w_wr_lvl;
  logic [IDX_W-1:0]      w_wr_idx;

  // Handshake decode and credit check: a pop is only issued when the word it
  // returns is guaranteed a free slot, counting the word already in flight.
  // NOTE: every always_comb output gets a value on every path (here by
  // unconditional assignment), otherwise synthesis infers a latch.
  always_comb begin
    w_pop       = (r_level != '0) && bus.m_ready;
    w_push      = r_inflight && !flush;
    w_committed = {1'b0, r_level} + {{LVL_W{1'b0}}, r_inflight}
                - {{LVL_W{1'b0}}, w_pop};
    w_rd_en     = !rst_rd && !bus.rd_empty && !flush
                && (w_committed < (LVL_W+1)'(BUF_DEPTH));
    // Tail slot after this cycle's pop has shifted the entries down.
    w_wr_lvl    = r_level - {{(LVL_W-1){1'b0}}, w_pop};
    w_wr_idx    = w_wr_lvl[IDX_W-1:0];
  end

  // Buffer storage: entry 0 is the head; a pop shifts everything down and an
  // arrival lands just behind the last surviving entry.
  // NOTE: the buffer is reset (it is only a few words) so m_data reads 0
  // out of reset instead of X.
  always_ff @(posedge clk_rd or posedge rst_rd) begin
    if (rst_rd) begin
      for (int i = 0; i < BUF_DEPTH; i++) r_buf[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make the shift and the tail write see
      // pre-edge values; the tail write is last so it wins on the same slot.
      if (w_pop) begin
        for (int i = 0; i < BUF_DEPTH - 1; i++) r_buf[i] <= r_buf[i+1];
      end
      if (w_push && (w_wr_lvl < LVL_W'(BUF_DEPTH))) begin
        r_buf[w_wr_idx] <= bus.rdata;
      end
    end
  end

  // Occupancy and read-latency tracking; flush empties the buffer and drops
  // whatever word arrives on the same edge.
  always_ff @(posedge clk_rd or posedge rst_rd) begin
    if (rst_rd) begin
      r_level    <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      if (flush) r_level <= '0;
      else       r_level <= r_level + {{(LVL_W-1){1'b0}}, w_push}
                                    - {{(LVL_W-1){1'b0}}, w_pop};
    end
  end

  // Delivered-word counter; a handshake in a flush cycle still counts.
  always_ff @(posedge clk_rd or posedge rst_rd) begin
    if (rst_rd) r_cnt <= '0;
    else if (w_pop) r_cnt <= r_cnt + 1'b1;
  end

  assign bus.rd_en   = w_rd_en;
  assign bus.m_valid = (r_level != '0);
  assign bus.m_data  = r_buf[0];
  assign word_cnt    = r_cnt;
  assign buf_level   = r_level;

endmodule

// File: tb/tb_afifo_rd_stream.sv
// Bench for afifo_rd_stream: a queue-based AFIFO model feeds the DUT, every
// popped word is pushed to an expected-stream queue, and an independent
// monitor pops and compares on each downstream handshake.
module tb_afifo_rd_stream;
  localparam int DW = 32;
  localparam int D  = 2;
  localparam int CW = 4;
  localparam int LW = $clog2(D + 1);

  logic          clk_rd = 1'b0;
  logic          rst_rd;
  logic          flush;
  logic [CW-1:0] word_cnt;
  logic [LW-1:0] buf_level;

  afifo_rd_stream_if #(.DATA_WIDTH(DW)) bus ();

  afifo_rd_stream #(.DATA_WIDTH(DW), .BUF_DEPTH(D), .CNT_WIDTH(CW)) dut (
    .clk_rd    (clk_rd),
    .rst_rd    (rst_rd),
    .bus       (bus),
    .flush     (flush),
    .word_cnt  (word_cnt),
    .buf_level (buf_level)
  );

  always #5 clk_rd = ~clk_rd;

  int          checks = 0;
  int          errors = 0;
  logic [DW-1:0] afifo_q[$];   // words still inside the AFIFO
  logic [DW-1:0] exp_q[$];     // words owned by the DUT (arriving + buffered), in order
  int          hs_cyc[$];      // cycle index of every downstream handshake
  int          cyc = 0;
  bit          arrive = 1'b0;  // a popped word is on rdata this cycle
  bit          prev_rd_en = 1'b0;
  bit          flushed;
  int          rd_en_cnt;
  bit          done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One read-domain cycle: AFIFO returns last cycle's pop, then inputs are set.
  task automatic cycle(input bit rdy, input bit fl, input bit emp_force,
                       input bit flush_on_inflight = 1'b0);
    @(negedge clk_rd);
    cyc++;
    rst_rd = 1'b0;
    arrive = prev_rd_en;
    if (arrive) begin
      bus.rdata = afifo_q.pop_front();
      exp_q.push_back(bus.rdata);
    end
    bus.m_ready  = rdy;
    flushed      = fl || (flush_on_inflight && arrive && buf_level != '0);
    flush        = flushed;
    bus.rd_empty = (afifo_q.size() == 0) || emp_force;
    #1;
    prev_rd_en = bus.rd_en;
    if (bus.rd_en) rd_en_cnt++;
    check("rd_en_while_empty", {63'd0, bus.rd_en && bus.rd_empty}, 64'd0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_rd);
      cyc++;
      rst_rd       = 1'b1;
      arrive       = 1'b0;
      prev_rd_en   = 1'b0;
      flush        = 1'b0;
      bus.m_ready  = 1'b0;
      bus.rd_empty = (afifo_q.size() == 0);
      #1;
      check("rd_en_in_reset", {63'd0, bus.rd_en}, 64'd0);
    end
  endtask

  // Monitor: level/valid from the ownership model, data order on handshakes.
  initial begin : monitor
    int lvl_exp;
    int exp_cnt;
    exp_cnt = 0;
    while (!done) begin
      @(negedge clk_rd);
      #2;
      if (rst_rd) begin
        check("rst_buf_level", {62'd0, buf_level}, 64'd0);
        check("rst_m_valid", {63'd0, bus.m_valid}, 64'd0);
        check("rst_word_cnt", {60'd0, word_cnt}, 64'd0);
        check("rst_m_data", {32'd0, bus.m_data}, 64'd0);
        exp_q.delete();
        exp_cnt = 0;
      end else begin
        lvl_exp = exp_q.size() - int'(arrive);
        check("buf_level", {62'd0, buf_level}, 64'(lvl_exp));
        check("m_valid", {63'd0, bus.m_valid}, {63'd0, lvl_exp != 0});
        check("word_cnt", {60'd0, word_cnt}, 64'(exp_cnt % (1 << CW)));
        if (arrive && !flush && buf_level == LW'(D) && !(bus.m_valid && bus.m_ready)) begin
          checks++; errors++;
          $display("FAIL overflow: arrival with buf_level %0d and no pop (cycle %0d)", buf_level, cyc);
        end
        if (bus.m_valid && bus.m_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_word: got %0h expected none (cycle %0d)", bus.m_data, cyc);
          end else begin
            check("m_data", {32'd0, bus.m_data}, {32'd0, exp_q.pop_front()});
          end
          exp_cnt++;
          hs_cyc.push_back(cyc);
        end
        if (flush) exp_q.delete();
      end
    end
  end

  initial begin : driver
    int n0;
    logic [CW-1:0] cnt_before;
    rst_rd = 1'b1; flush = 1'b0;
    bus.m_ready = 1'b0; bus.rd_empty = 1'b1; bus.rdata = '0;

    // Reset with a word waiting, then first-word latency.
    afifo_q.push_back(32'hA5A5_A5A5);
    do_reset(3);
    cycle(1, 0, 0);
    check("first_rd_en", {63'd0, prev_rd_en}, 64'd1);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    check("first_m_valid", {63'd0, bus.m_valid}, 64'd1);
    check("first_m_data", {32'd0, bus.m_data}, 64'hA5A5_A5A5);
    cycle(1, 0, 0);
    check("first_word_cnt", {60'd0, word_cnt}, 64'd1);

    // Streaming without bubbles.
    for (int i = 0; i < 8; i++) afifo_q.push_back(DW'(i));
    n0 = hs_cyc.size();
    for (int i = 0; i < 12; i++) cycle(1, 0, 0);
    check("stream_words", 64'(hs_cyc.size() - n0), 64'd8);
    if (hs_cyc.size() - n0 == 8)
      check("stream_no_bubble", 64'(hs_cyc[n0+7] - hs_cyc[n0]), 64'd7);
    check("stream_cnt", {60'd0, word_cnt}, 64'd9);
    check("stream_idle_valid", {63'd0, bus.m_valid}, 64'd0);

    // Backpressure.
    for (int i = 0; i < 8; i++) afifo_q.push_back(DW'(i));
    rd_en_cnt = 0;
    for (int i = 0; i < 10; i++) cycle(0, 0, 0);
    check("bp_rd_en_count", 64'(rd_en_cnt), 64'(D));
    check("bp_level", {62'd0, buf_level}, 64'(D));
    check("bp_hold_data", {32'd0, bus.m_data}, 64'd0);
    n0 = hs_cyc.size();
    for (int i = 0; i < 14; i++) cycle(1, 0, 0);
    check("bp_delivered", 64'(hs_cyc.size() - n0), 64'd8);

    // Flush while a word is in flight and one is buffered.
    for (int i = 0; i < 4; i++) afifo_q.push_back(DW'(32'h10 + i));
    flushed = 1'b0;
    for (int i = 0; i < 8 && !flushed; i++) cycle(0, 0, 0, 1'b1);
    if (!flushed) begin
      checks++; errors++;
      $display("FAIL flush_setup: got no in-flight window expected one within 8 cycles");
    end
    cnt_before = word_cnt;
    cycle(0, 0, 0);
    check("flush_m_valid", {63'd0, bus.m_valid}, 64'd0);
    check("flush_level", {62'd0, buf_level}, 64'd0);
    check("flush_cnt", {60'd0, word_cnt}, {60'd0, cnt_before});
    n0 = hs_cyc.size();
    for (int i = 0; i < 10; i++) cycle(1, 0, 0);
    check("flush_survivors", 64'(hs_cyc.size() - n0), 64'd2);

    // rd_empty toggling every cycle.
    for (int i = 0; i < 10; i++) afifo_q.push_back($urandom);
    n0 = hs_cyc.size();
    for (int i = 0; i < 40; i++) cycle(1, 0, cyc[0]);
    check("toggle_delivered", 64'(hs_cyc.size() - n0), 64'd10);
    check("toggle_afifo_drained", 64'(afifo_q.size()), 64'd0);

    // Random mix of traffic, backpressure, empties and flushes.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0 && afifo_q.size() < 6) afifo_q.push_back($urandom);
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0);
    end
    for (int i = 0; i < 20; i++) cycle(1, 0, 0);
    check("rand_afifo_drained", 64'(afifo_q.size()), 64'd0);
    check("rand_idle_valid", {63'd0, bus.m_valid}, 64'd0);

    // Reset mid-stream, then counter wrap over 17 words.
    for (int i = 0; i < 6; i++) afifo_q.push_back($urandom);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0);
    afifo_q.delete();
    do_reset(2);
    for (int i = 0; i < 17; i++) afifo_q.push_back(DW'(32'h100 + i));
    n0 = hs_cyc.size();
    for (int i = 0; i < 25; i++) cycle(1, 0, 0);
    check("wrap_delivered", 64'(hs_cyc.size() - n0), 64'd17);
    check("wrap_word_cnt", {60'd0, word_cnt}, 64'd1);

    done = 1'b1;
    @(negedge clk_rd);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
